// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Write-side scheduler that shares the single write port of the asynchronous
// FIFO (fifo1) among NREQ requesters living in the write clock domain.
// Round-robin arbitration with bounded burst ownership: once a requester wins
// it keeps the port for up to MAX_BURST consecutive beats, then priority
// rotates to the next requester after it. No data words are stored here; the
// accepted requester's word is muxed straight onto wdata in the cycle it is
// written, and nothing is ever written while wfull is high.
//
// Optional feature macro: FIFO_WR_ARB_STATS_EN
//   defined     : per-requester saturating 16-bit accepted-word counters
//   not defined : stat_cnt tied to zero, counters not built
//
// Parameters:
//   DSIZE      data word width (must match the FIFO's DSIZE)
//   NREQ       number of requesters, 2..8
//   MAX_BURST  maximum consecutive beats per ownership, 1..255
//   IDW        grant index width, $clog2(NREQ)
//
// Ports:
//   wclk       in   write-domain clock (only clock)
//   wrst       in   synchronous active-high reset
//   req_valid  in   [NREQ]        per-requester word valid
//   req_data   in   [NREQ*DSIZE]  requester i word at [i*DSIZE +: DSIZE]
//   req_ready  out  [NREQ]        one-hot-or-zero, word of requester i written
//   winc       out                FIFO write strobe
//   wdata      out  [DSIZE]       FIFO write data
//   wfull      in                 FIFO full flag (wclk domain)
//   grant_id   out  [IDW]         requester written this cycle (valid with winc)
//   busy       out                high while a burst owner holds the port
//   stat_cnt   out  [NREQ*16]     per-requester accepted-word counters
//
// FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | round-robin search from last+1; a transfer starts a burst
//   ST_OWN   | owner holds the port; others ignored until burst ends/drops
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    parameter int IDW       = $clog2(NREQ)
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    input  logic                    wfull,
    output logic [IDW-1:0]          grant_id,
    output logic                    busy,
    output logic [NREQ*16-1:0]      stat_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    localparam logic [7:0]     BURST_LAST = 8'(MAX_BURST);
    localparam logic [IDW-1:0] LAST_RST   = IDW'(NREQ - 1);

    state_e         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] last_q,  last_d;
    logic [7:0]     beats_q, beats_d;

    logic [IDW-1:0] sel;
    logic [IDW-1:0] cand;
    logic           sel_valid;
    logic [7:0]     beats_inc;

    // -------------------------------------------------------------------------
    // Requester selection. In IDLE the candidates are scanned from the lowest
    // priority (last+NREQ, i.e. last itself) up to the highest (last+1), so the
    // final overwrite leaves the first valid requester after last.
    // -------------------------------------------------------------------------
    always_comb begin : sel_logic
        sel       = owner_q;
        sel_valid = 1'b0;
        cand      = '0;
        if (state_q == ST_OWN) begin
            sel       = owner_q;
            sel_valid = req_valid[owner_q];
        end else begin
            for (int k = NREQ; k >= 1; k--) begin
                cand = IDW'((int'(last_q) + k) % NREQ);
                if (req_valid[cand]) begin
                    sel       = cand;
                    sel_valid = 1'b1;
                end
            end
        end
    end

    // Reset gating keeps the FIFO untouched in the reset cycle even though
    // state is only cleared at the following edge.
    assign winc     = sel_valid & ~wfull & ~wrst;
    assign grant_id = sel;
    assign busy     = (state_q == ST_OWN) & ~wrst;

    always_comb begin : datapath
        wdata     = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == IDW'(i)) begin
                wdata        = req_data[i*DSIZE +: DSIZE];
                req_ready[i] = winc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    assign beats_inc = beats_q + 8'd1;

    always_comb begin : next_state
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beats_d = beats_q;
        case (state_q)
            ST_IDLE: begin
                if (winc) begin
                    if (MAX_BURST == 1) begin
                        // single-beat bursts never enter OWN
                        last_d = sel;
                    end else begin
                        state_d = ST_OWN;
                        owner_d = sel;
                        beats_d = 8'd1;
                    end
                end
            end
            ST_OWN: begin
                if (!sel_valid) begin
                    // owner went away: give up the port, arbitrate next cycle
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                    beats_d = 8'd0;
                end else if (winc) begin
                    if (beats_inc == BURST_LAST) begin
                        state_d = ST_IDLE;
                        last_d  = owner_q;
                        beats_d = 8'd0;
                    end else begin
                        beats_d = beats_inc;
                    end
                end
                // owner valid with wfull high: stall, everything holds
            end
            default: begin
                state_d = ST_IDLE;
                beats_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge wclk) begin : state_reg
        if (wrst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            beats_q <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

    // -------------------------------------------------------------------------
    // Accepted-word statistics
    // -------------------------------------------------------------------------
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stat_q [NREQ];
    logic [15:0] stat_d [NREQ];

    always_comb begin : stat_next
        for (int i = 0; i < NREQ; i++) begin
            stat_d[i] = stat_q[i];
            if (winc && (sel == IDW'(i)) && (stat_q[i] != 16'hFFFF)) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge wclk) begin : stat_reg
        for (int i = 0; i < NREQ; i++) begin
            if (wrst) begin
                stat_q[i] <= 16'd0;
            end else begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    always_comb begin : stat_pack
        stat_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            stat_cnt[i*16 +: 16] = stat_q[i];
        end
    end
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int MB    = 4;
    localparam int IDW   = 2;
    localparam int BOUND = (NREQ - 1) * MB + 1;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic                  wfull;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
    logic [NREQ*16-1:0]    stat_cnt;

    // second instance with single-beat bursts
    logic [NREQ-1:0]       req_valid_1;
    logic [NREQ*DSIZE-1:0] req_data_1;
    logic [NREQ-1:0]       req_ready_1;
    logic                  winc_1;
    logic [DSIZE-1:0]      wdata_1;
    logic [IDW-1:0]        grant_id_1;
    logic                  busy_1;
    logic [NREQ*16-1:0]    stat_cnt_1;

    fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MB), .IDW(IDW)) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .winc(winc), .wdata(wdata), .wfull(wfull),
        .grant_id(grant_id), .busy(busy), .stat_cnt(stat_cnt)
    );

    fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(1), .IDW(IDW)) dut1 (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid_1), .req_data(req_data_1),
        .req_ready(req_ready_1), .winc(winc_1), .wdata(wdata_1), .wfull(wfull),
        .grant_id(grant_id_1), .busy(busy_1), .stat_cnt(stat_cnt_1)
    );

    always #5 wclk = ~wclk;

    int tests = 0;
    int fails = 0;

    // reference model: current burst owner (-1 = nobody), last writer, beats
    int m_owner;
    int m_last;
    int m_beats;
    int m_stat [NREQ];
    int wait_cyc [NREQ];
    logic [DSIZE-1:0] dat [NREQ];
    logic [NREQ-1:0]  pending;

    logic             obs_winc, obs_busy, obs_winc_1, obs_busy_1;
    logic [IDW-1:0]   obs_gid, obs_gid_1;
    logic [NREQ-1:0]  obs_ready;
    logic [DSIZE-1:0] obs_wdata_1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = NREQ - 1;
        m_beats = 0;
        for (int i = 0; i < NREQ; i++) begin
            m_stat[i]   = 0;
            wait_cyc[i] = 0;
        end
    endtask

    // One cycle: drive at negedge, check outputs against the model, advance.
    task automatic step(input logic [NREQ-1:0] v, input logic full, input logic rst,
                        input logic [NREQ-1:0] v1);
        int g;
        logic ew;
        logic [NREQ*16-1:0] es;
        @(negedge wclk);
        req_valid   = v;
        wfull       = full;
        wrst        = rst;
        req_valid_1 = v1;
        for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = dat[i];
        #1;
        g = -1;
        if (!rst) begin
            if (m_owner < 0) begin
                for (int k = 1; k <= NREQ; k++)
                    if (g < 0 && v[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
            end else if (v[m_owner]) begin
                g = m_owner;
            end
        end
        ew = (g >= 0) && !full;
        chk("winc", winc, ew);
        chk("req_ready", req_ready, ew ? (64'd1 << g) : 64'd0);
        if (ew) begin
            chk("grant_id", grant_id, g);
            chk("wdata", wdata, dat[g]);
        end
        chk("busy", busy, (!rst && m_owner >= 0));
        es = '0;
`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) es[i*16 +: 16] = 16'(m_stat[i]);
`endif
        chk("stat_cnt", stat_cnt, es);
        obs_winc    = winc;
        obs_busy    = busy;
        obs_gid     = grant_id;
        obs_ready   = req_ready;
        obs_winc_1  = winc_1;
        obs_busy_1  = busy_1;
        obs_gid_1   = grant_id_1;
        obs_wdata_1 = wdata_1;
        @(posedge wclk);
        // fairness: every pending requester written within BOUND non-full cycles
        for (int i = 0; i < NREQ; i++) begin
            if (rst || !v[i]) begin
                wait_cyc[i] = 0;
            end else if (!full) begin
                wait_cyc[i]++;
                if (ew && g == i) begin
                    chk("fair_bound", wait_cyc[i] <= BOUND, 1'b1);
                    wait_cyc[i] = 0;
                end
            end
        end
        if (rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            if (ew) begin
                if (MB == 1) m_last = g;
                else begin
                    m_owner = g;
                    m_beats = 1;
                end
            end
        end else if (!v[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (!full) begin
            m_beats++;
            if (m_beats == MB) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        if (ew) begin
            if (m_stat[g] < 65535) m_stat[g]++;
            dat[g] = DSIZE'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) dat[i] = DSIZE'($urandom);
        req_data_1  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid   = '0;
        req_valid_1 = '0;
        req_data    = '0;
        wfull       = 1'b0;
        wrst        = 1'b1;
        pending     = '0;
        model_reset();
        repeat (2) @(posedge wclk);

        // reset holds everything quiet even with all requesters valid
        step(4'hF, 1'b0, 1'b1, 4'h0);
        step(4'hF, 1'b0, 1'b1, 4'h0);

        // all valid: 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0
        for (int i = 0; i < 17; i++) begin
            step(4'hF, 1'b0, 1'b0, 4'h0);
            chk("rr_winc", obs_winc, 1'b1);
            chk("rr_gid", obs_gid, (i / 4) % 4);
        end
        step(4'h0, 1'b0, 1'b0, 4'h0);

        // req 2 alone for 2 beats, then drops
        step(4'b0100, 1'b0, 1'b0, 4'h0);
        chk("r2_gid_a", obs_gid, 2);
        step(4'b0100, 1'b0, 1'b0, 4'h0);
        chk("r2_gid_b", obs_gid, 2);
        step(4'h0, 1'b0, 1'b0, 4'h0);
        chk("r2_drop_busy", obs_busy, 1'b1);
        chk("r2_drop_winc", obs_winc, 1'b0);
        step(4'h0, 1'b0, 1'b0, 4'h0);
        chk("r2_busy_fall", obs_busy, 1'b0);
        step(4'b1010, 1'b0, 1'b0, 4'h0);
        chk("after2_gid", obs_gid, 3);
        step(4'h0, 1'b0, 1'b0, 4'h0);

        // owner 1, beats 2, then 5 full cycles
        step(4'b0010, 1'b0, 1'b0, 4'h0);
        step(4'b0010, 1'b0, 1'b0, 4'h0);
        chk("own1_gid", obs_gid, 1);
        for (int i = 0; i < 5; i++) begin
            step(4'b0010, 1'b1, 1'b0, 4'h0);
            chk("stall_winc", obs_winc, 1'b0);
            chk("stall_ready", obs_ready, 4'h0);
            chk("stall_busy", obs_busy, 1'b1);
        end
        step(4'b0010, 1'b0, 1'b0, 4'h0);
        chk("resume_a", obs_winc, 1'b1);
        step(4'b0010, 1'b0, 1'b0, 4'h0);
        chk("resume_b", obs_winc, 1'b1);
        step(4'b0110, 1'b0, 1'b0, 4'h0);
        chk("burst_end_gid", obs_gid, 2);
        step(4'h0, 1'b0, 1'b0, 4'h0);

        // reset in the middle of owner 3's burst
        step(4'b1000, 1'b0, 1'b0, 4'h0);
        step(4'b1000, 1'b0, 1'b0, 4'h0);
        chk("own3_gid", obs_gid, 3);
        step(4'hF, 1'b0, 1'b1, 4'h0);
        chk("rst_mid_winc", obs_winc, 1'b0);
        step(4'hF, 1'b0, 1'b0, 4'h0);
        chk("post_rst_gid", obs_gid, 0);
        step(4'h0, 1'b0, 1'b0, 4'h0);

        // single-beat instance: strict alternation, never busy
        for (int i = 0; i < 8; i++) begin
            step(4'h0, 1'b0, 1'b0, 4'b0011);
            chk("mb1_winc", obs_winc_1, 1'b1);
            chk("mb1_gid", obs_gid_1, i % 2);
            chk("mb1_wdata", obs_wdata_1, (i % 2 == 0) ? 8'h11 : 8'h22);
            chk("mb1_busy", obs_busy_1, 1'b0);
        end

        // randomized traffic, backpressure and occasional reset
        for (int n = 0; n < 3000; n++) begin
            step(pending, ($urandom_range(0, 4) == 0), ($urandom_range(0, 199) == 0), 4'h0);
            for (int i = 0; i < NREQ; i++) begin
                if (obs_ready[i]) pending[i] = 1'b0;
                if (!pending[i] && $urandom_range(0, 2) == 0) pending[i] = 1'b1;
            end
        end

`ifdef FIFO_WR_ARB_STATS_EN
        step(4'h0, 1'b0, 1'b1, 4'h0);
        for (int n = 0; n < 70000; n++) step(4'b0001, 1'b0, 1'b0, 4'h0);
        step(4'h0, 1'b0, 1'b0, 4'h0);
        chk("stat0_sat", stat_cnt[15:0], 16'hFFFF);
        chk("stat_others", stat_cnt[NREQ*16-1:16], '0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
